controle_barramento: RTL
========================

Name: controle_barramento

Overview:
- Multi-cycle sequencer that owns the shared 16-bit data bus of the processor datapath.
- Generates the direction control `io` of the temp (ALU operand A) register, plus:
  - register-bank address, output-enable and write-enable
  - ALU operation select and the G (result) register load/drive controls
  - immediate drive
- Accepts one instruction at a time through a start/ready handshake with a one-entry command buffer, so back-to-back instructions run with no idle cycle.

Parameters:
- Tamanho_Da_Palavra, 16, data/immediate width.
- Bits_Endereco, 3, register-bank address width (8 registers).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  command valid; accepted on an edge where start && ready.
- ready  output  1  = !pend_v (command buffer empty).
- opcode  input  3  000 MV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 MVI, 110/111 reserved.
- rx  input  Bits_Endereco  destination and operand-A register.
- ry  input  Bits_Endereco  operand-B / source register.
- dado_imediato  input  Tamanho_Da_Palavra  immediate for MVI.
- rb_addr  output  Bits_Endereco  register-bank address.
- rb_oe  output  1  register bank drives bus.
- rb_we  output  1  register bank writes bus into rb_addr at the next edge.
- temp_io  output  1  temp direction: 1 = temp captures bus, bus released; 0 = temp drives bus.
- ula_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- g_en  output  1  G register loads ALU result.
- g_oe  output  1  G drives bus.
- imm_oe  output  1  immediate drives bus.
- imediato  output  Tamanho_Da_Palavra  immediate value; 0 when imm_oe=0.
- done  output  1  one-cycle pulse in an instruction's final cycle.
- erro  output  1  one-cycle pulse for a reserved opcode, coincident with done.

Behaviour:
- Command buffer
  - On an edge with start && ready, {opcode, rx, ry, dado_imediato} is latched and pend_v is set to 1.
  - The FSM pops the buffer on an edge where the state is IDLE or a final state (WB, MV_WB, IMM, NOP). That edge clears pend_v.
  - Since ready=0 while pend_v=1, a push and a pop never occur on the same edge.
- Latency
  - The first execution state begins one cycle after the accepting edge.
  - Cycle counts: ALU ops 3, MV 2, MVI 1, reserved 1.
- FSM states and outputs
  - Outputs are Moore-decoded from the state register and the latched command. Any output not listed is 0, except temp_io, which defaults to 1.
  - IDLE: all defaults.
  - X_LOAD (ALU ops): rb_addr=rx, rb_oe=1. Temp captures operand A. Next state Y_ULA.
  - Y_ULA: rb_addr=ry, rb_oe=1, g_en=1, ula_op=opcode-1. Next state WB.
  - WB: g_oe=1, rb_addr=rx, rb_we=1, done=1.
  - MV_LOAD: rb_addr=ry, rb_oe=1. Next state MV_WB.
  - MV_WB: temp_io=0, rb_addr=rx, rb_we=1, done=1.
  - IMM: imm_oe=1, imediato=latched immediate, rb_addr=rx, rb_we=1, done=1.
  - NOP (reserved opcode): done=1, erro=1. No bus or write activity.
  - Leaving a final state: next state is the popped command's first state if pend_v=1, otherwise IDLE.
- Bus exclusivity invariant, every cycle: at most one of {rb_oe, g_oe, imm_oe, !temp_io} is 1.
- ula_op is 00 outside Y_ULA.
- Reset
  - Reset at any cycle forces IDLE and clears pend_v and the buffer. All outputs take their IDLE values: ready=1, temp_io=1, rest 0.
  - An interrupted instruction produces no rb_we and no done.
  - start asserted together with reset is ignored.

Test Plan:
- Reset held 2 cycles, then released with start=0 -> ready=1, temp_io=1, all other outputs 0, imediato=0, for 5 cycles.
- ADD rx=1, ry=2 accepted at edge E0:
  - cycle E0+1: rb_addr=1, rb_oe=1.
  - cycle E0+2: rb_addr=2, rb_oe=1, g_en=1, ula_op=00.
  - cycle E0+3: g_oe=1, rb_we=1, rb_addr=1, done=1.
  - then IDLE.
- MV rx=3, ry=5 -> cycle 1: rb_addr=5, rb_oe=1, temp_io=1; cycle 2: temp_io=0, rb_addr=3, rb_we=1, done=1. temp_io=0 in no other cycle.
- MVI rx=4, dado_imediato=16'hBEEF -> exactly one cycle of imm_oe=1, imediato=16'hBEEF, rb_we=1, rb_addr=4, done=1.
- Back-to-back handshake:
  - SUB (3,6) accepted, then start held with OR (7,1).
  - OR is accepted the edge after SUB is popped.
  - ready=0 while OR is pending.
  - OR's X_LOAD immediately follows SUB's WB with no IDLE gap; ula_op=11 in its Y_ULA.
- Abort and reserved opcode:
  - reset asserted during Y_ULA of an AND with a pending MV -> no rb_we, no done, pending MV discarded, ready=1 after release.
  - then opcode 111 -> one cycle done=1, erro=1, no bus enables.
- Bus exclusivity invariant asserted throughout all scenarios.

Source files
------------

// File: rtl/controle_barramento.sv
// Shared-bus sequencer: turns one instruction at a time into register-bank, temp, ALU, G and
// immediate controls. A one-entry command buffer lets back-to-back instructions run gap-free.
module controle_barramento #(
    parameter int unsigned Tamanho_Da_Palavra = 16,
    parameter int unsigned Bits_Endereco      = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          ready,
    input  logic [2:0]                    opcode,
    input  logic [Bits_Endereco-1:0]      rx,
    input  logic [Bits_Endereco-1:0]      ry,
    input  logic [Tamanho_Da_Palavra-1:0] dado_imediato,
    output logic [Bits_Endereco-1:0]      rb_addr,
    output logic                          rb_oe,
    output logic                          rb_we,
    output logic                          temp_io,
    output logic [1:0]                    ula_op,
    output logic                          g_en,
    output logic                          g_oe,
    output logic                          imm_oe,
    output logic [Tamanho_Da_Palavra-1:0] imediato,
    output logic                          done,
    output logic                          erro
);

    typedef enum logic [2:0] {
        StIdle, StXLoad, StYUla, StWb, StMvLoad, StMvWb, StImm, StNop
    } estado_t;

    estado_t r_estado;
    estado_t w_proximo;

    logic                          r_pend_v;
    logic [2:0]                    r_pend_op;
    logic [Bits_Endereco-1:0]      r_pend_rx;
    logic [Bits_Endereco-1:0]      r_pend_ry;
    logic [Tamanho_Da_Palavra-1:0] r_pend_imm;

    logic [2:0]                    r_cur_op;
    logic [Bits_Endereco-1:0]      r_cur_rx;
    logic [Bits_Endereco-1:0]      r_cur_ry;
    logic [Tamanho_Da_Palavra-1:0] r_cur_imm;

    logic       w_final;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_op_menos_um;

    function automatic estado_t primeiro_estado(input logic [2:0] op);
        case (op)
            3'b000:                         primeiro_estado = StMvLoad;
            3'b001, 3'b010, 3'b011, 3'b100: primeiro_estado = StXLoad;
            3'b101:                         primeiro_estado = StImm;
            default:                        primeiro_estado = StNop;
        endcase
    endfunction

    // IDLE and the final states are the only points where the next command may be popped.
    assign w_final = (r_estado == StIdle) || (r_estado == StWb) || (r_estado == StMvWb) ||
                     (r_estado == StImm)  || (r_estado == StNop);
    assign w_push        = start && !r_pend_v;
    assign w_pop         = w_final && r_pend_v;
    assign ready         = !r_pend_v;
    assign w_op_menos_um = r_cur_op - 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= StIdle;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_v   <= 1'b0;
            r_pend_op  <= '0;
            r_pend_rx  <= '0;
            r_pend_ry  <= '0;
            r_pend_imm <= '0;
            r_cur_op   <= '0;
            r_cur_rx   <= '0;
            r_cur_ry   <= '0;
            r_cur_imm  <= '0;
        end else begin
            if (w_push) begin
                r_pend_v   <= 1'b1;
                r_pend_op  <= opcode;
                r_pend_rx  <= rx;
                r_pend_ry  <= ry;
                r_pend_imm <= dado_imediato;
            end else if (w_pop) begin
                r_pend_v <= 1'b0;
            end
            if (w_pop) begin
                r_cur_op  <= r_pend_op;
                r_cur_rx  <= r_pend_rx;
                r_cur_ry  <= r_pend_ry;
                r_cur_imm <= r_pend_imm;
            end
        end
    end

    always_comb begin
        w_proximo = StIdle;
        case (r_estado)
            StXLoad:  w_proximo = StYUla;
            StYUla:   w_proximo = StWb;
            StMvLoad: w_proximo = StMvWb;
            default:  w_proximo = r_pend_v ? primeiro_estado(r_pend_op) : StIdle;
        endcase
    end

    always_comb begin
        rb_addr  = '0;
        rb_oe    = 1'b0;
        rb_we    = 1'b0;
        temp_io  = 1'b1;
        ula_op   = 2'b00;
        g_en     = 1'b0;
        g_oe     = 1'b0;
        imm_oe   = 1'b0;
        imediato = '0;
        done     = 1'b0;
        erro     = 1'b0;
        case (r_estado)
            StXLoad: begin
                rb_addr = r_cur_rx;
                rb_oe   = 1'b1;
            end
            StYUla: begin
                rb_addr = r_cur_ry;
                rb_oe   = 1'b1;
                g_en    = 1'b1;
                ula_op  = w_op_menos_um[1:0];
            end
            StWb: begin
                g_oe    = 1'b1;
                rb_addr = r_cur_rx;
                rb_we   = 1'b1;
                done    = 1'b1;
            end
            StMvLoad: begin
                rb_addr = r_cur_ry;
                rb_oe   = 1'b1;
            end
            StMvWb: begin
                temp_io = 1'b0;
                rb_addr = r_cur_rx;
                rb_we   = 1'b1;
                done    = 1'b1;
            end
            StImm: begin
                imm_oe   = 1'b1;
                imediato = r_cur_imm;
                rb_addr  = r_cur_rx;
                rb_we    = 1'b1;
                done     = 1'b1;
            end
            StNop: begin
                done = 1'b1;
                erro = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
